core_debug_ctrl: RTL

//  Run-control sequencer for the single-cycle core: halts, resumes and single/N-steps it by gating core_en.

---
 rtl/dbg_pkg.sv | 26 ++
 rtl/core_debug_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dbg_pkg.sv
// Shared types and constants for the core run-control / debug sequencer.
package dbg_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_IDX_W    = 5;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_HALT  = 3'd1,
    OP_RUN   = 3'd2,
    OP_STEP  = 3'd3,
    OP_RDREG = 3'd4,
    OP_SETBP = 3'd5,
    OP_CLRBP = 3'd6,
    OP_RDPC  = 3'd7
  } dbg_op_e;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_HALTED = 3'd1,
    ST_STEP   = 3'd2,
    ST_RDREG  = 3'd3,
    ST_RSP    = 3'd4
  } dbg_state_e;

endpackage

// File: rtl/core_debug_ctrl.sv
// Run-control sequencer: halts/resumes/steps the core via core_en, reads the RF
// through the shared debug read port, and owns a single PC breakpoint.
//
//  state  | meaning
//  RUN    | core free-running, stops in front of a breakpoint hit
//  HALTED | core stalled, RF read port available to debug
//  STEP   | core commits once per cycle until the step counter expires
//  RDREG  | debug read port drives the RF, data captured at end of cycle
//  RSP    | one-cycle response pulse, then back to RUN or HALTED
module core_debug_ctrl
  import dbg_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int STEP_W       = 16,
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [XLEN-1:0]      cmd_arg,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic [XLEN-1:0]      rsp_data,
  input  logic [XLEN-1:0]      pc_in,
  output logic                 core_en,
  output logic                 rf_dbg_en,
  output logic [REG_IDX_W-1:0] rf_dbg_addr,
  input  logic [XLEN-1:0]      rf_dbg_data,
  output logic                 halted
);

  dbg_state_e        state, state_nxt;
  dbg_op_e           op;
  logic              fire, cmd_illegal, bp_hit, step_last;
  logic [STEP_W-1:0] cnt, cnt_load;
  logic              bp_valid;
  logic [XLEN-1:0]   bp_addr;
  logic              rsp_halt_q, rsp_run_q, rsp_pc_q, rsp_err_q;
  logic [XLEN-1:0]   rsp_data_q;

  assign op          = dbg_op_e'(cmd_op);
  assign cmd_ready   = (state == ST_RUN) || (state == ST_HALTED);
  assign fire        = cmd_valid && cmd_ready;
  assign cmd_illegal = ((op == OP_STEP) || (op == OP_RDREG)) && (state != ST_HALTED);
  assign bp_hit      = bp_valid && (pc_in == bp_addr);
  assign step_last   = (cnt <= STEP_W'(1));
  assign cnt_load    = (cmd_arg[STEP_W-1:0] == '0) ? STEP_W'(1) : cmd_arg[STEP_W-1:0];

  assign halted    = (state == ST_HALTED);
  assign rsp_valid = (state == ST_RSP);
  assign rsp_err   = rsp_valid && rsp_err_q;
  // HALT and STEP report the PC the core settled on, which is only known in RSP
  assign rsp_data  = (rsp_valid && rsp_pc_q) ? pc_in : rsp_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (RESET_HALTED) state <= ST_HALTED;
      else              state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    core_en   = 1'b0;
    case (state)
      ST_RUN, ST_HALTED: begin
        if (state == ST_RUN) core_en = !bp_hit;
        if (fire) begin
          if (!cmd_illegal && (op == OP_STEP))       state_nxt = ST_STEP;
          else if (!cmd_illegal && (op == OP_RDREG)) state_nxt = ST_RDREG;
          else                                       state_nxt = ST_RSP;
        end else if ((state == ST_RUN) && bp_hit) begin
          state_nxt = ST_HALTED;
        end
      end
      ST_STEP: begin
        core_en = 1'b1;
        if (step_last) state_nxt = ST_RSP;
      end
      ST_RDREG: state_nxt = ST_RSP;
      ST_RSP: begin
        core_en   = rsp_run_q && !bp_hit;
        state_nxt = rsp_halt_q ? ST_HALTED : ST_RUN;
      end
      default: state_nxt = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      bp_valid    <= 1'b0;
      bp_addr     <= '0;
      rsp_halt_q  <= 1'b0;
      rsp_run_q   <= 1'b0;
      rsp_pc_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      rf_dbg_en   <= 1'b0;
      rf_dbg_addr <= '0;
    end else if (fire) begin
      rsp_err_q  <= cmd_illegal;
      rsp_pc_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_halt_q <= (state == ST_HALTED);
      rsp_run_q  <= (state == ST_RUN);
      case (op)
        OP_HALT: begin
          rsp_halt_q <= 1'b1;
          rsp_run_q  <= 1'b0;
          rsp_pc_q   <= 1'b1;
        end
        OP_RUN: rsp_halt_q <= 1'b0;
        OP_STEP: if (!cmd_illegal) begin
          cnt      <= cnt_load;
          rsp_pc_q <= 1'b1;
        end
        OP_RDREG: if (!cmd_illegal) begin
          rf_dbg_en   <= 1'b1;
          rf_dbg_addr <= cmd_arg[REG_IDX_W-1:0];
        end
        OP_SETBP: begin
          bp_valid <= 1'b1;
          bp_addr  <= cmd_arg;
        end
        OP_CLRBP: bp_valid <= 1'b0;
        OP_RDPC:  rsp_data_q <= pc_in;
        default: ;
      endcase
    end else if (state == ST_STEP) begin
      cnt <= cnt - STEP_W'(1);
    end else if (state == ST_RDREG) begin
      rf_dbg_en  <= 1'b0;
      rsp_data_q <= (rf_dbg_addr == '0) ? '0 : rf_dbg_data;
    end
  end

endmodule
